// File: rtl/exec_sequencer_pkg.sv
// Shared types for exec_sequencer: FSM states, instruction classes, latched control word.
// Optional feature macro used by the top: PERF_CNT_EN.
package exec_sequencer_pkg;

  localparam int PC_W_DEF  = 5;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IC_NOP    = 3'd0,
    IC_BRANCH = 3'd1,
    IC_LOAD   = 3'd2,
    IC_STORE  = 3'd3,
    IC_RTYPE  = 3'd4
  } iclass_t;

  typedef struct packed {
    logic       reg_we;
    logic       data_we;
    logic       wsel;
    logic       branch;
    logic [4:0] branch_off;
    logic [4:0] data_addr;
  } ctrl_t;

  // Branch wins over everything, then store, then load, then R-type.
  function automatic iclass_t classify(input ctrl_t c);
    iclass_t k;
    if (c.branch)                k = IC_BRANCH;
    else if (c.data_we)          k = IC_STORE;
    else if (c.reg_we && !c.wsel) k = IC_LOAD;
    else if (c.reg_we && c.wsel)  k = IC_RTYPE;
    else                         k = IC_NOP;
    return k;
  endfunction

endpackage

// File: rtl/exec_sequencer_perf_counters.sv
// Busy-cycle and retired-instruction counters; both wrap at 2^CNT_W.
module exec_sequencer_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (busy)   r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (retire) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM: FETCH / DECODE / EXEC / MEM / WB around the decoder; owns the PC.
// Define PERF_CNT_EN to build the cycle/instret counters; otherwise both ports read 0.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_reg_we,
  input  logic             dec_data_we,
  input  logic             dec_wsel,
  input  logic             dec_branch,
  input  logic [4:0]       dec_branch_off,
  input  logic [4:0]       dec_data_addr,
  input  logic             alu_zero,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [4:0]       dmem_addr,
  input  logic             dmem_ack,
  output logic             ld_capture,
  output logic             reg_we,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Handshakes: a request is held with stable address/attributes until the
  // matching ack is seen in the same cycle; acks arriving without a request are ignored.

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [PC_W-1:0]   w_pc_inc;
  ctrl_t             r_ctrl;
  ctrl_t             w_dec_ctrl;
  iclass_t           w_class;
  state_t            w_after_retire;

  assign w_dec_ctrl = '{reg_we:     dec_reg_we,
                        data_we:    dec_data_we,
                        wsel:       dec_wsel,
                        branch:     dec_branch,
                        branch_off: dec_branch_off,
                        data_addr:  dec_data_addr};

  assign w_class        = classify(r_ctrl);
  assign w_pc_inc       = r_pc + PC_W'(1);
  assign w_after_retire = run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == ST_DECODE) r_ctrl <= w_dec_ctrl;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    imem_req     = 1'b0;
    imem_addr    = '0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ld_capture   = 1'b0;
    reg_we       = 1'b0;
    retire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        if (imem_ack) begin
          ir_load      = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (w_class)
          IC_BRANCH: begin
            // Offset is zero-extended; the sum wraps at the PC width.
            w_pc_next    = alu_zero ? (r_pc + PC_W'(r_ctrl.branch_off)) : w_pc_inc;
            retire       = 1'b1;
            w_state_next = w_after_retire;
          end
          IC_LOAD, IC_STORE: w_state_next = ST_MEM;
          IC_RTYPE:          w_state_next = ST_WB;
          default: begin
            w_pc_next    = w_pc_inc;
            retire       = 1'b1;
            w_state_next = w_after_retire;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_ctrl.data_we;
        if (dmem_ack) begin
          if (w_class == IC_STORE) begin
            w_pc_next    = w_pc_inc;
            retire       = 1'b1;
            w_state_next = w_after_retire;
          end else begin
            ld_capture   = 1'b1;
            w_state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we       = 1'b1;
        w_pc_next    = w_pc_inc;
        retire       = 1'b1;
        w_state_next = w_after_retire;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign dmem_addr = r_ctrl.data_addr;
  assign pc        = r_pc;
  assign busy      = (r_state != ST_IDLE);

`ifdef PERF_CNT_EN
  exec_sequencer_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: directed scenarios plus randomized instruction stream
// checked against a per-instruction latency / PC model.
module tb_exec_sequencer;

  localparam int PC_W  = 5;
  localparam int CNT_W = 32;
  localparam int K_NOP = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_RT = 4;

  logic             clk, rst_n, run;
  logic             imem_req, imem_ack, ir_load;
  logic [PC_W-1:0]  imem_addr;
  logic             dec_reg_we, dec_data_we, dec_wsel, dec_branch;
  logic [4:0]       dec_branch_off, dec_data_addr;
  logic             alu_zero;
  logic             dmem_req, dmem_we, dmem_ack, ld_capture, reg_we;
  logic [4:0]       dmem_addr;
  logic [PC_W-1:0]  pc;
  logic             busy, retire;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  exec_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .ir_load        (ir_load),
    .dec_reg_we     (dec_reg_we),
    .dec_data_we    (dec_data_we),
    .dec_wsel       (dec_wsel),
    .dec_branch     (dec_branch),
    .dec_branch_off (dec_branch_off),
    .dec_data_addr  (dec_data_addr),
    .alu_zero       (alu_zero),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_ack       (dmem_ack),
    .ld_capture     (ld_capture),
    .reg_we         (reg_we),
    .pc             (pc),
    .busy           (busy),
    .retire         (retire),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [PC_W-1:0] exp_q[$];
  int m_pc      = 0;
  int m_busy    = 0;
  int m_retired = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef PERF_CNT_EN
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(m_busy));
    check({tag, "_instret_cnt"}, 64'(instret_cnt), 64'(m_retired));
`else
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    check({tag, "_instret_cnt"}, 64'(instret_cnt), 64'd0);
`endif
  endtask

  task automatic random_decoder();
    dec_reg_we     = 1'($urandom_range(0, 1));
    dec_data_we    = 1'($urandom_range(0, 1));
    dec_wsel       = 1'($urandom_range(0, 1));
    dec_branch     = 1'($urandom_range(0, 1));
    dec_branch_off = 5'($urandom_range(0, 31));
    dec_data_addr  = 5'($urandom_range(0, 31));
  endtask

  task automatic drive_decoder(input int kind, input logic [4:0] off, input logic [4:0] addr);
    dec_branch     = (kind == K_BR);
    dec_data_we    = (kind == K_ST);
    dec_reg_we     = (kind == K_LD) || (kind == K_RT);
    dec_wsel       = (kind == K_RT) ? 1'b1 :
                     (kind == K_LD) ? 1'b0 : 1'($urandom_range(0, 1));
    dec_branch_off = off;
    dec_data_addr  = addr;
  endtask

  // Leaves IDLE: after this the DUT is in its first fetch cycle.
  task automatic start();
    run = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    random_decoder();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_pc = 0; m_busy = 0; m_retired = 0;
  endtask

  // Executes one instruction, playing imem, decoder, ALU and dmem.
  // Entry: sampling point of the fetch cycle. Exit: sampling point after retire.
  task automatic do_instr(input string tag, input int kind, input int imem_dly, input int dmem_dly,
                          input bit az, input bit keep_run, input logic [4:0] off, input logic [4:0] addr);
    int  exp_total, exp_pc, cyc, f_wait, m_wait;
    int  n_reg_we, n_dmem, n_ldcap, n_irload, n_busy, reg_we_cyc, retire_cyc;
    bit  done, dec_now, dec_next, is_mem, has_wb;
    is_mem    = (kind == K_LD) || (kind == K_ST);
    has_wb    = (kind == K_LD) || (kind == K_RT);
    exp_total = imem_dly + 3 + ((kind == K_LD) ? dmem_dly + 2 :
                                (kind == K_ST) ? dmem_dly + 1 :
                                (kind == K_RT) ? 1 : 0);
    exp_pc    = (kind == K_BR && az) ? (m_pc + int'(off)) % (1 << PC_W) : (m_pc + 1) % (1 << PC_W);
    exp_q.push_back(PC_W'(exp_pc));
    cyc = 1; f_wait = 0; m_wait = 0; done = 0; dec_next = 0;
    n_reg_we = 0; n_dmem = 0; n_ldcap = 0; n_irload = 0; n_busy = 0; reg_we_cyc = -1; retire_cyc = -1;
    check({tag, "_req_first"}, 64'(imem_req), 64'd1);
    while (!done && cyc <= 200) begin
      dec_now  = dec_next;
      dec_next = 0;
      if (busy) n_busy++;
      alu_zero = az;
      if (dec_now) drive_decoder(kind, off, addr);
      else random_decoder();
      if (imem_req) begin
        if (imem_addr !== PC_W'(m_pc)) check({tag, "_imem_addr"}, 64'(imem_addr), 64'(m_pc));
        imem_ack = (f_wait == imem_dly);
        dec_next = imem_ack;
        f_wait++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
        if (!keep_run) run = 1'b0;
      end
      if (dmem_req) begin
        n_dmem++;
        if (dmem_we !== (kind == K_ST)) check({tag, "_dmem_we"}, 64'(dmem_we), 64'(kind == K_ST));
        if (dmem_addr !== addr) check({tag, "_dmem_addr"}, 64'(dmem_addr), 64'(addr));
        dmem_ack = (m_wait == dmem_dly);
        m_wait++;
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (ir_load) n_irload++;
      if (ld_capture) n_ldcap++;
      if (reg_we) begin n_reg_we++; reg_we_cyc = cyc; end
      if (retire) begin retire_cyc = cyc; done = 1; end
      tick();
      cyc++;
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(retire_cyc), 64'(exp_total));
    check({tag, "_pc"}, 64'(pc), 64'(exp_q.pop_front()));
    check({tag, "_ir_load_n"}, 64'(n_irload), 64'd1);
    check({tag, "_reg_we_n"}, 64'(n_reg_we), 64'(has_wb));
    if (has_wb) check({tag, "_reg_we_at_retire"}, 64'(reg_we_cyc), 64'(retire_cyc));
    check({tag, "_dmem_cycles"}, 64'(n_dmem), is_mem ? 64'(dmem_dly + 1) : 64'd0);
    check({tag, "_ld_capture_n"}, 64'(n_ldcap), 64'(kind == K_LD));
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'(exp_total));
    m_pc = exp_pc;
    m_busy += exp_total;
    m_retired++;
    if (!keep_run) begin
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        tick();
        check({tag, "_idle_no_req"}, 64'(imem_req), 64'd0);
      end
      imem_ack = 1'b0;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int kind, idly, ddly;
    bit az, kr;
    do_reset();
    check("reset_imem_req", 64'(imem_req), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pc", 64'(pc), 64'd0);
    check("reset_dmem_req", 64'(dmem_req), 64'd0);
    check("reset_reg_we", 64'(reg_we), 64'd0);
    check("reset_retire", 64'(retire), 64'd0);
    check_counters("reset");

    start();
    do_instr("rtype", K_RT, 0, 0, 1'b0, 1'b1, 5'd3, 5'd9);
    do_instr("load7", K_LD, 0, 3, 1'b0, 1'b1, 5'd0, 5'd7);
    do_instr("br_to30", K_BR, 0, 0, 1'b1, 1'b1, 5'd28, 5'd0);
    do_instr("beq_wrap", K_BR, 0, 0, 1'b1, 1'b1, 5'd4, 5'd0);
    do_instr("br_to30b", K_BR, 1, 0, 1'b1, 1'b1, 5'd28, 5'd0);
    do_instr("beq_not", K_BR, 0, 0, 1'b0, 1'b1, 5'd4, 5'd0);
    do_instr("nop_wrap", K_NOP, 0, 0, 1'b1, 1'b1, 5'd0, 5'd0);
    do_instr("store_stop", K_ST, 1, 2, 1'b0, 1'b0, 5'd0, 5'd21);
    check_counters("after_stop");

    // Reset while a fetch is stalled waiting for its ack.
    start();
    imem_ack = 1'b0;
    tick(); tick();
    check("stall_req", 64'(imem_req), 64'd1);
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("rst_req_drop", 64'(imem_req), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    m_pc = 0; m_busy = 0; m_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    tick(); tick();
    check("late_ack_idle", 64'(busy), 64'd0);
    check("late_ack_pc", 64'(pc), 64'd0);
    imem_ack = 1'b0;
    check_counters("after_async_rst");

    start();
    for (int i = 0; i < 3; i++) do_instr("nop3", K_NOP, 0, 0, 1'b0, 1'b1, 5'd0, 5'd0);
    check_counters("three_nops");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      idly = $urandom_range(0, 3);
      ddly = $urandom_range(0, 3);
      az   = 1'($urandom_range(0, 1));
      kr   = ($urandom_range(0, 5) != 0);
      do_instr("rand", kind, idly, ddly, az, kr, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (!kr) start();
    end
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
